// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite types for the SRAM slave: transfer type, size and burst
// encodings, response codes, slave FSM states, and the byte-enable helper.
// No ports.
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Byte enables for a bus up to 64 bits wide (8 lanes). The caller clamps
    // hsize to its own lane count and slices off the lanes it has. The lane
    // offset is aligned down to the transfer size, little-endian.
    function automatic logic [7:0] size_to_be(input logic [2:0] hsize,
                                              input logic [2:0] addr_lsb);
        logic [2:0] sz;
        logic [2:0] base;
        logic [7:0] mask;
        sz = (hsize > 3'd3) ? 3'd3 : hsize;
        case (sz)
            3'd0:    mask = 8'h01;
            3'd1:    mask = 8'h03;
            3'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        base = (addr_lsb >> sz) << sz;
        return mask << base;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ---------------------------------------------------------------------------
// ahb_sram_mem
// DEPTH x DATA_WIDTH flop array with a byte-enable synchronous write port and
// an asynchronous read port sharing one word address. Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write strobe (commits enabled lanes on the rising edge)
//   be_i     byte-lane enables, bit n covers wdata_i[8n+7:8n]
//   addr_i   word index for both read and write
//   wdata_i  write data
//   rdata_o  combinational read of mem[addr_i]
// ---------------------------------------------------------------------------
module ahb_sram_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned NB        = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [NB-1:0]         be_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-Lite slave fronting a flop-array SRAM. Address phase is captured into
// data-phase registers; the data phase optionally stretches HREADYOUT by
// WAIT_STATES cycles, then commits the write lanes or returns read data.
// Build option: define AHB_SRAM_ERR_EN to answer out-of-range addresses and
// oversize HSIZE with a two-cycle ERROR; otherwise addresses wrap modulo
// DEPTH, oversize HSIZE acts as full width and HRESP stays OKAY.
// Ports:
//   HCLK, HRESETn           clock, async active-low reset
//   HSEL, HADDR, HTRANS,    address-phase controls from the decoder/master
//   HWRITE, HSIZE
//   HBURST, HPROT, HMASTLOCK accepted and ignored
//   HWDATA                  write data (data phase)
//   HREADY                  muxed bus ready
//   HRDATA, HREADYOUT, HRESP slave responses
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned NB        = DATA_WIDTH / 8;
    localparam int unsigned LANE_BITS = $clog2(NB);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [2:0]       MAX_SIZE  = 3'(LANE_BITS);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    htrans_e               trans;
    logic                  accept;
    logic                  a_err;
    logic [IDX_W-1:0]      a_idx;
    logic [LANE_BITS-1:0]  a_lsb;
    logic [2:0]            a_size;

    slv_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
    logic [LANE_BITS-1:0]  dp_lsb_q, dp_lsb_d;
    logic [2:0]            dp_size_q, dp_size_d;

    logic                  hready_int;
    logic                  hresp_int;
    logic                  mem_we;
    logic [7:0]            be_full;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_ok;

    assign trans  = htrans_e'(HTRANS);
    assign accept = HSEL && HREADY && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
    assign a_idx  = HADDR[LANE_BITS +: IDX_W];
    assign a_lsb  = HADDR[LANE_BITS-1:0];
    assign a_size = (HSIZE > MAX_SIZE) ? MAX_SIZE : HSIZE;

`ifdef AHB_SRAM_ERR_EN
    assign a_err = (HADDR[ADDR_WIDTH-1:LANE_BITS+IDX_W] != '0) || (HSIZE > MAX_SIZE);
`else
    assign a_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        dp_lsb_d   = dp_lsb_q;
        dp_size_d  = dp_size_q;
        hready_int = 1'b1;
        hresp_int  = HRESP_OKAY;

        case (state_q)
            ST_WAIT: begin
                hready_int = 1'b0;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef AHB_SRAM_ERR_EN
            ST_ERR1: begin
                hready_int = 1'b0;
                hresp_int  = HRESP_ERROR;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_int = HRESP_ERROR;
                state_d   = ST_IDLE;
            end
`endif
            default: ;
        endcase

        // The current data phase ends on any cycle HREADYOUT is high; a new
        // address phase may be taken in that same cycle (including ERR2).
        // Error accesses never become a valid data phase, so they cannot
        // write memory or drive read data.
        if (hready_int) begin
            dp_valid_d = 1'b0;
            if (accept) begin
                dp_write_d = HWRITE;
                dp_idx_d   = a_idx;
                dp_lsb_d   = a_lsb;
                dp_size_d  = a_size;
                if (a_err) begin
                    state_d = ST_ERR1;
                end else begin
                    dp_valid_d = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_lsb_q   <= '0;
            dp_size_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_lsb_q   <= dp_lsb_d;
            dp_size_q  <= dp_size_d;
        end
    end

    assign mem_we  = dp_valid_q && dp_write_q && (state_q == ST_IDLE);
    assign be_full = size_to_be(dp_size_q, 3'(dp_lsb_q));
    assign mem_be  = be_full[NB-1:0];

    ahb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (dp_idx_q),
        .wdata_i (HWDATA),
        .rdata_o (mem_rdata)
    );

    assign HRDATA    = (dp_valid_q && !dp_write_q && (state_q == ST_IDLE)) ? mem_rdata : '0;
    assign HREADYOUT = hready_int;
    assign HRESP     = hresp_int;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR[ADDR_WIDTH-1:LANE_BITS+IDX_W], be_full};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
// Two slaves on one bus: u_dut0 with zero wait states, u_dut1 with two.
// tgt selects which slave is addressed; HREADY is the muxed HREADYOUT.
// Expectations come from a reference memory and go through a scoreboard
// queue that the monitor drains when each data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;

    logic        HCLK;
    logic        HRESETn;
    logic        tgt;
    logic        sel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;

    logic        hsel0, hsel1;
    logic        hready;
    logic [31:0] rd0, rd1;
    logic        ro0, ro1, rsp0, rsp1;
    logic [31:0] hrdata;
    logic        hresp;

    assign hsel0  = sel & ~tgt;
    assign hsel1  = sel & tgt;
    assign hready = tgt ? ro1 : ro0;
    assign hresp  = tgt ? rsp1 : rsp0;
    assign hrdata = tgt ? rd1 : rd0;

    ahb_lite_sram_slave #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .DEPTH (256), .WAIT_STATES (0)
    ) u_dut0 (
        .HCLK (HCLK), .HRESETn (HRESETn), .HSEL (hsel0), .HADDR (HADDR),
        .HTRANS (HTRANS), .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST),
        .HPROT (HPROT), .HMASTLOCK (HMASTLOCK), .HWDATA (HWDATA), .HREADY (hready),
        .HRDATA (rd0), .HREADYOUT (ro0), .HRESP (rsp0)
    );

    ahb_lite_sram_slave #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .DEPTH (256), .WAIT_STATES (2)
    ) u_dut1 (
        .HCLK (HCLK), .HRESETn (HRESETn), .HSEL (hsel1), .HADDR (HADDR),
        .HTRANS (HTRANS), .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST),
        .HPROT (HPROT), .HMASTLOCK (HMASTLOCK), .HWDATA (HWDATA), .HREADY (hready),
        .HRDATA (rd1), .HREADYOUT (ro1), .HRESP (rsp1)
    );

    typedef struct {
        logic        is_read;
        logic        err;
        logic        known;
        logic [31:0] data;
        int unsigned waits;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl   [2][256];
    logic        known [2][256];
    logic [31:0] pend_wd;
    int unsigned n_checks;
    int unsigned n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // Drive one address phase (plus the previous transfer's HWDATA), wait
    // for it to be accepted, then record what its data phase must return.
    task automatic addr_phase(input logic s, input logic [1:0] tr, input logic wr,
                              input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd);
        int unsigned n;
        int unsigned nbytes;
        int unsigned base;
        logic        r;
        logic        err;
        logic [7:0]  idx;
        logic [31:0] w;
        exp_t        e;
        sel    = s;
        HTRANS = tr;
        HWRITE = wr;
        HADDR  = a;
        HSIZE  = sz;
        HWDATA = pend_wd;
        n = 0;
        do begin
            @(negedge HCLK);
            r = hready;
            @(posedge HCLK);
            n++;
        end while (!r && n < 64);
        #1;
        if (!r) check_eq("accept_timeout", 64'(n), 64'd0);
        if (s && tr[1]) begin
            err = 1'b0;
`ifdef AHB_SRAM_ERR_EN
            err = (a[31:10] != 22'd0) || (sz > 3'd2);
`endif
            idx       = a[9:2];
            e.is_read = !wr;
            e.err     = err;
            e.waits   = err ? 1 : (tgt ? 2 : 0);
            e.known   = err ? 1'b1 : known[tgt][idx];
            e.data    = err ? 32'd0 : mdl[tgt][idx];
            sb_q.push_back(e);
            if (wr && !err) begin
                nbytes = 1 << ((sz > 3'd2) ? 2 : int'(sz));
                base   = int'(a[1:0]) - (int'(a[1:0]) % nbytes);
                w      = mdl[tgt][idx];
                for (int unsigned b = 0; b < 4; b++) begin
                    if (b >= base && b < base + nbytes) w[8*b +: 8] = wd[8*b +: 8];
                end
                mdl[tgt][idx] = w;
                if (nbytes == 4) known[tgt][idx] = 1'b1;
            end
        end
        pend_wd = wd;
    endtask

    task automatic bus_idle();
        addr_phase(1'b0, 2'b00, 1'b0, 32'd0, 3'd2, 32'd0);
    endtask

    // Monitor: follows the data phase on the bus and checks each cycle.
    initial begin : monitor
        logic        busy;
        int unsigned waits;
        exp_t        e;
        busy  = 1'b0;
        waits = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                busy  = 1'b0;
                waits = 0;
                sb_q.delete();
            end else begin
                if (busy) begin
                    if (!hready) begin
                        waits++;
                        check_eq("wait_hrdata", 64'(hrdata), 64'd0);
                        if (sb_q.size() > 0) check_eq("wait_hresp", 64'(hresp), 64'(sb_q[0].err));
                    end else begin
                        if (sb_q.size() == 0) begin
                            check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
                        end else begin
                            e = sb_q.pop_front();
                            check_eq("hresp", 64'(hresp), 64'(e.err));
                            check_eq("wait_count", 64'(waits), 64'(e.waits));
                            if (e.is_read && e.known) check_eq("hrdata", 64'(hrdata), 64'(e.data));
                        end
                        busy  = 1'b0;
                        waits = 0;
                    end
                end
                if (hready) busy = sel & HTRANS[1];
            end
        end
    end

    initial begin
        logic [31:0] saved;
        n_checks  = 0;
        n_errors  = 0;
        HRESETn   = 1'b0;
        tgt       = 1'b0;
        sel       = 1'b0;
        HADDR     = '0;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        HSIZE     = 3'd2;
        HBURST    = '0;
        HPROT     = '0;
        HMASTLOCK = 1'b0;
        HWDATA    = '0;
        pend_wd   = '0;
        for (int i = 0; i < 256; i++) begin
            known[0][i] = 1'b0;
            known[1][i] = 1'b0;
            mdl[0][i]   = '0;
            mdl[1][i]   = '0;
        end

        repeat (3) @(posedge HCLK);
        #1;
        check_eq("rst_hreadyout0", 64'(ro0), 64'd1);
        check_eq("rst_hresp0",     64'(rsp0), 64'd0);
        check_eq("rst_hrdata0",    64'(rd0), 64'd0);
        check_eq("rst_hreadyout1", 64'(ro1), 64'd1);
        check_eq("rst_hresp1",     64'(rsp1), 64'd0);
        check_eq("rst_hrdata1",    64'(rd1), 64'd0);
        HRESETn = 1'b1;
        bus_idle();

        // Zero-wait slave: back-to-back write/read, then sub-word writes.
        addr_phase(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b1, 32'h11, 3'd0, 32'h0000AA00);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b1, 32'h12, 3'd1, 32'h12340000);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
        bus_idle();
        check_eq("bytewrite_model", 64'(mdl[0][4]), 64'h1234AAEF);

        // Fill words 0..7 as a SEQ burst, then read them back.
        for (int i = 0; i < 8; i++) begin
            if (i != 4)
                addr_phase(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b1, 32'(4*i), 3'd2, $urandom);
        end
        for (int i = 0; i < 8; i++)
            addr_phase(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, 32'(4*i), 3'd2, 32'h0);
        bus_idle();

        // Unselected and BUSY write phases must not touch memory.
        addr_phase(1'b1, 2'b01, 1'b1, 32'h10, 3'd2, 32'hFFFFFFFF);
        check_eq("busy_hreadyout", 64'(ro0), 64'd1);
        check_eq("busy_hresp",     64'(rsp0), 64'd0);
        addr_phase(1'b0, 2'b10, 1'b1, 32'h10, 3'd2, 32'hFFFFFFFF);
        check_eq("nosel_hreadyout", 64'(ro0), 64'd1);
        check_eq("nosel_hresp",     64'(rsp0), 64'd0);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
        bus_idle();

        // Out-of-range write, pipelined read of word 0, then more edge cases.
        addr_phase(1'b1, 2'b10, 1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h0, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h404, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h8, 3'd3, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h4, 3'd2, 32'h0);
        bus_idle();

        // Two-wait-state slave.
        tgt = 1'b1;
        addr_phase(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h0BADF00D);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b1, 32'h24, 3'd2, 32'h55555555);
        addr_phase(1'b1, 2'b10, 1'b1, 32'h23, 3'd0, 32'h7E000000);
        addr_phase(1'b1, 2'b11, 1'b0, 32'h20, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b11, 1'b0, 32'h24, 3'd2, 32'h0);
        bus_idle();

        // Reset in the middle of a wait-stretched write drops the write.
        saved = mdl[1][9];
        addr_phase(1'b1, 2'b10, 1'b1, 32'h24, 3'd2, 32'hAAAAAAAA);
        sel    = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'hAAAAAAAA;
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_eq("midrst_hreadyout", 64'(ro1), 64'd1);
        check_eq("midrst_hresp",     64'(rsp1), 64'd0);
        check_eq("midrst_hrdata",    64'(rd1), 64'd0);
        mdl[1][9] = saved;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        pend_wd = '0;
        bus_idle();
        addr_phase(1'b1, 2'b10, 1'b0, 32'h24, 3'd2, 32'h0);
        addr_phase(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
        bus_idle();
        bus_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
